rtc_core: RTL and testbench

Parametrised single-clock timekeeper with an editable alarm. It replaces the divided 1 Hz clock with a clock-enable prescaler, so the whole block runs on `clk`. It adds a 12/24-hour display mode, an hh:mm alarm with timed ring-out, and a field cursor shared by time-set and alarm-set modes. It sits between the debounced button pulses and the seven-segment display driver.

---
 rtl/rtc_if.sv | 33 +++
 rtl/rtc_core.sv | 170 +++++++++++++++++
 tb/tb_rtc_core.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_if.sv
// Button/mode inputs and time/display outputs of the timekeeper, bundled as one port.
// The master side drives modes and button pulses; the slave side is rtc_core.
interface rtc_if;
  logic       set_mod;
  logic       alarm_mod;
  logic       alarm_en;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [5:0] disp_hours;
  logic [5:0] disp_minutes;
  logic [5:0] disp_seconds;
  logic       pm;
  logic [1:0] pos;
  logic       sec_tick;
  logic       ring;

  modport master (
    output set_mod, alarm_mod, alarm_en, left, right, up, down,
    input  hours, minutes, seconds, disp_hours, disp_minutes, disp_seconds,
    input  pm, pos, sec_tick, ring
  );

  modport slave (
    input  set_mod, alarm_mod, alarm_en, left, right, up, down,
    output hours, minutes, seconds, disp_hours, disp_minutes, disp_seconds,
    output pm, pos, sec_tick, ring
  );
endinterface

// File: rtl/rtc_core.sv
// Single-clock timekeeper: clock-enable prescaler, hh:mm:ss counter, hh:mm alarm
// with timed ring-out, shared field cursor for time-set / alarm-set, 12/24 h display.
//
// state   | meaning
// RS_IDLE | alarm silent, waiting for the tick that lands on alarm hh:mm:00
// RS_RING | alarm sounding; ring counter runs down once per second
module rtc_core #(
  parameter int CLK_HZ    = 100000000,
  parameter bit MODE_12H  = 1'b0,
  parameter int RING_SECS = 60
) (
  input logic  clk,
  input logic  reset,
  rtc_if.slave bus
);
  localparam int            PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_HZ - 1);
  localparam logic [7:0]    RING_LOAD = 8'(RING_SECS);

  typedef enum logic {RS_IDLE, RS_RING} ring_state_e;

  function automatic logic [5:0] field_step(input logic [5:0] v, input logic [5:0] top,
                                            input logic inc, input logic dec);
    if (inc)      return (v >= top) ? 6'd0 : v + 6'd1;
    else if (dec) return (v == 6'd0) ? top : v - 6'd1;
    else          return v;
  endfunction

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [5:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [5:0]    ah_q, ah_d, am_q, am_d;
  logic [1:0]    pos_q, pos_d;
  logic [7:0]    rcnt_q, rcnt_d;
  ring_state_e   st_q, st_d;

  logic          is_set, is_alarm, tick, any_btn, btn_live;
  logic          inc_en, dec_en, mv_r, mv_l, trig;
  logic [5:0]    src_h, disp_h;
  logic          pm_d;

  // While ringing, every button pulse is spent on silencing the alarm.
  assign is_set   = bus.set_mod;
  assign is_alarm = !bus.set_mod && bus.alarm_mod;
  assign tick     = !is_set && (pcnt_q == PCNT_LAST);
  assign any_btn  = bus.left | bus.right | bus.up | bus.down;
  assign btn_live = any_btn && (st_q == RS_IDLE);
  assign inc_en   = btn_live && bus.up && !bus.down;
  assign dec_en   = btn_live && bus.down && !bus.up;
  assign mv_r     = btn_live && bus.right && !bus.left;
  assign mv_l     = btn_live && bus.left && !bus.right;

  // Prescaler, running time with carries, and field edits of time or alarm.
  always_comb begin
    pcnt_d = pcnt_q;
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    ah_d   = ah_q;
    am_d   = am_q;
    if (is_set || tick) pcnt_d = '0;
    else                pcnt_d = pcnt_q + 1'b1;
    if (tick) begin
      ss_d = field_step(ss_q, 6'd59, 1'b1, 1'b0);
      if (ss_q == 6'd59) begin
        mm_d = field_step(mm_q, 6'd59, 1'b1, 1'b0);
        if (mm_q == 6'd59) hh_d = field_step(hh_q, 6'd23, 1'b1, 1'b0);
      end
    end
    if (is_set) begin
      case (pos_q)
        2'd0:    hh_d = field_step(hh_q, 6'd23, inc_en, dec_en);
        2'd1:    mm_d = field_step(mm_q, 6'd59, inc_en, dec_en);
        default: ss_d = field_step(ss_q, 6'd59, inc_en, dec_en);
      endcase
    end else if (is_alarm) begin
      if (pos_q == 2'd0)      ah_d = field_step(ah_q, 6'd23, inc_en, dec_en);
      else if (pos_q == 2'd1) am_d = field_step(am_q, 6'd59, inc_en, dec_en);
    end
  end

  // Cursor: three fields in time-set, two in alarm-set (seconds slot snaps to hours).
  always_comb begin
    pos_d = pos_q;
    if (is_set) begin
      if (mv_r)      pos_d = (pos_q >= 2'd2) ? 2'd0 : pos_q + 2'd1;
      else if (mv_l) pos_d = (pos_q == 2'd0) ? 2'd2 : pos_q - 2'd1;
    end else if (is_alarm) begin
      if (pos_q >= 2'd2)     pos_d = 2'd0;
      else if (mv_r || mv_l) pos_d = {1'b0, ~pos_q[0]};
    end
  end

  // Ring FSM: start on the matching tick, stop on timeout, button, disarm or time-set.
  always_comb begin
    st_d   = st_q;
    rcnt_d = rcnt_q;
    trig   = tick && bus.alarm_en && (ss_q == 6'd59) && (mm_d == am_q) && (hh_d == ah_q);
    case (st_q)
      RS_IDLE: begin
        if (trig) begin
          st_d   = RS_RING;
          rcnt_d = RING_LOAD;
        end
      end
      RS_RING: begin
        if (is_set || !bus.alarm_en || any_btn) begin
          st_d   = RS_IDLE;
          rcnt_d = '0;
        end else if (tick) begin
          rcnt_d = rcnt_q - 8'd1;
          if (rcnt_q <= 8'd1) st_d = RS_IDLE;
        end
      end
      default: st_d = RS_IDLE;
    endcase
  end

  // Display hour source and optional 12 h conversion.
  always_comb begin
    src_h  = is_alarm ? ah_q : hh_q;
    disp_h = src_h;
    pm_d   = 1'b0;
    if (MODE_12H) begin
      if (src_h == 6'd0) begin
        disp_h = 6'd12;
      end else if (src_h > 6'd12) begin
        disp_h = src_h - 6'd12;
        pm_d   = 1'b1;
      end else if (src_h == 6'd12) begin
        pm_d   = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      hh_q   <= '0;
      mm_q   <= '0;
      ss_q   <= '0;
      ah_q   <= '0;
      am_q   <= '0;
      pos_q  <= '0;
      rcnt_q <= '0;
      st_q   <= RS_IDLE;
    end else begin
      pcnt_q <= pcnt_d;
      hh_q   <= hh_d;
      mm_q   <= mm_d;
      ss_q   <= ss_d;
      ah_q   <= ah_d;
      am_q   <= am_d;
      pos_q  <= pos_d;
      rcnt_q <= rcnt_d;
      st_q   <= st_d;
    end
  end

  assign bus.hours        = hh_q;
  assign bus.minutes      = mm_q;
  assign bus.seconds      = ss_q;
  assign bus.disp_hours   = disp_h;
  assign bus.disp_minutes = is_alarm ? am_q : mm_q;
  assign bus.disp_seconds = is_alarm ? 6'd0 : ss_q;
  assign bus.pm           = pm_d;
  assign bus.pos          = pos_q;
  assign bus.sec_tick     = tick;
  assign bus.ring         = (st_q == RS_RING);
endmodule

// File: tb/tb_rtc_core.sv
// Directed bench for rtc_core with CLK_HZ=10, MODE_12H=1, RING_SECS=3.
module tb_rtc_core;
  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  rtc_if bus();

  rtc_core #(.CLK_HZ(10), .MODE_12H(1'b1), .RING_SECS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic l, input logic r, input logic u, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      bus.left = l; bus.right = r; bus.up = u; bus.down = d;
      step(1);
      bus.left = 1'b0; bus.right = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    vecs++; if ({bus.hours, bus.minutes, bus.seconds} !== 18'd0) begin
      $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", bus.hours, bus.minutes, bus.seconds); errs++; end
    vecs++; if (bus.pos !== 2'd0) begin $display("FAIL reset_pos: got %0d want 0", bus.pos); errs++; end
    vecs++; if (bus.ring !== 1'b0) begin $display("FAIL reset_ring: got %0b want 0", bus.ring); errs++; end
    vecs++; if (bus.sec_tick !== 1'b0) begin $display("FAIL reset_tick: got %0b want 0", bus.sec_tick); errs++; end
    vecs++; if ({bus.disp_hours, bus.pm} !== {6'd12, 1'b0}) begin
      $display("FAIL reset_disp12: got %0d pm=%0b want 12 pm=0", bus.disp_hours, bus.pm); errs++; end
  endtask

  task automatic test_run;
    int bad;
    int ticks;
    bad = 0; ticks = 0;
    for (int k = 0; k < 600; k++) begin
      if (bus.sec_tick === 1'b1) ticks++;
      if (bus.sec_tick !== (k % 10 == 9)) bad++;
      step(1);
    end
    vecs++; if (bad != 0) begin $display("FAIL run_tick_phase: got %0d misplaced ticks want 0", bad); errs++; end
    vecs++; if (ticks != 60) begin $display("FAIL run_tick_count: got %0d want 60", ticks); errs++; end
    vecs++; if ({bus.hours, bus.minutes, bus.seconds} !== {6'd0, 6'd1, 6'd0}) begin
      $display("FAIL run_time: got %0d:%0d:%0d want 0:1:0", bus.hours, bus.minutes, bus.seconds); errs++; end
    vecs++; if (bus.pos !== 2'd0) begin $display("FAIL run_pos: got %0d want 0", bus.pos); errs++; end
  endtask

  task automatic test_edit;
    bus.set_mod = 1'b1;
    step(1);
    press(0, 0, 0, 1, 1);
    vecs++; if (bus.hours !== 6'd23) begin $display("FAIL edit_hours_dec: got %0d want 23", bus.hours); errs++; end
    press(0, 1, 0, 0, 1);
    vecs++; if (bus.pos !== 2'd1) begin $display("FAIL edit_pos_right: got %0d want 1", bus.pos); errs++; end
    press(0, 0, 0, 1, 3);
    vecs++; if (bus.minutes !== 6'd58) begin $display("FAIL edit_min_dec3: got %0d want 58", bus.minutes); errs++; end
    press(0, 0, 1, 1, 1);
    vecs++; if (bus.minutes !== 6'd58) begin $display("FAIL edit_updown: got %0d want 58", bus.minutes); errs++; end
    press(0, 0, 1, 0, 1);
    press(0, 1, 0, 0, 1);
    press(0, 0, 0, 1, 2);
    vecs++; if ({bus.hours, bus.minutes, bus.seconds} !== {6'd23, 6'd59, 6'd58}) begin
      $display("FAIL edit_preset: got %0d:%0d:%0d want 23:59:58", bus.hours, bus.minutes, bus.seconds); errs++; end
    press(0, 1, 0, 0, 1);
    vecs++; if (bus.pos !== 2'd0) begin $display("FAIL edit_pos_wrap: got %0d want 0", bus.pos); errs++; end
  endtask

  task automatic test_wrap;
    bus.set_mod = 1'b0;
    step(20);
    vecs++; if ({bus.hours, bus.minutes, bus.seconds} !== 18'd0) begin
      $display("FAIL wrap_midnight: got %0d:%0d:%0d want 0:0:0", bus.hours, bus.minutes, bus.seconds); errs++; end
    step(10);
    vecs++; if ({bus.hours, bus.minutes, bus.seconds} !== {6'd0, 6'd0, 6'd1}) begin
      $display("FAIL wrap_after: got %0d:%0d:%0d want 0:0:1", bus.hours, bus.minutes, bus.seconds); errs++; end
  endtask

  task automatic test_cursor;
    bus.set_mod = 1'b1;
    step(1);
    press(0, 1, 0, 0, 3);
    vecs++; if (bus.pos !== 2'd0) begin $display("FAIL cursor_right3: got %0d want 0", bus.pos); errs++; end
    press(1, 0, 0, 0, 1);
    vecs++; if (bus.pos !== 2'd2) begin $display("FAIL cursor_left_wrap: got %0d want 2", bus.pos); errs++; end
    press(1, 1, 0, 0, 1);
    vecs++; if (bus.pos !== 2'd2) begin $display("FAIL cursor_both: got %0d want 2", bus.pos); errs++; end
  endtask

  task automatic test_alarm_set;
    bus.set_mod = 1'b0;
    bus.alarm_mod = 1'b1;
    step(1);
    vecs++; if (bus.pos !== 2'd0) begin $display("FAIL alarm_pos_force: got %0d want 0", bus.pos); errs++; end
    vecs++; if ({bus.disp_hours, bus.pm, bus.disp_minutes, bus.disp_seconds} !== {6'd12, 1'b0, 6'd0, 6'd0}) begin
      $display("FAIL alarm_disp_init: got %0d pm=%0b :%0d:%0d want 12 pm=0 :0:0",
               bus.disp_hours, bus.pm, bus.disp_minutes, bus.disp_seconds); errs++; end
    press(0, 0, 1, 0, 7);
    press(0, 1, 0, 0, 1);
    press(0, 0, 0, 1, 30);
    vecs++; if ({bus.disp_hours, bus.pm, bus.disp_minutes} !== {6'd7, 1'b0, 6'd30}) begin
      $display("FAIL alarm_disp_0730: got %0d pm=%0b :%0d want 7 pm=0 :30", bus.disp_hours, bus.pm, bus.disp_minutes); errs++; end
    press(0, 1, 0, 0, 1);
    vecs++; if (bus.pos !== 2'd0) begin $display("FAIL alarm_pos_wrap: got %0d want 0", bus.pos); errs++; end
    step(60);
    vecs++; if ({bus.hours, bus.minutes, bus.seconds} !== {6'd0, 6'd0, 6'd11}) begin
      $display("FAIL alarm_time_runs: got %0d:%0d:%0d want 0:0:11", bus.hours, bus.minutes, bus.seconds); errs++; end
  endtask

  task automatic test_preset;
    bus.alarm_mod = 1'b0;
    bus.set_mod = 1'b1;
    step(1);
    press(0, 0, 1, 0, 7);
    press(0, 1, 0, 0, 1);
    press(0, 0, 0, 1, 31);
    press(0, 1, 0, 0, 1);
    press(0, 0, 0, 1, 12);
    vecs++; if ({bus.hours, bus.minutes, bus.seconds} !== {6'd7, 6'd29, 6'd59}) begin
      $display("FAIL preset_072959: got %0d:%0d:%0d want 7:29:59", bus.hours, bus.minutes, bus.seconds); errs++; end
  endtask

  task automatic test_ring;
    bus.alarm_en = 1'b1;
    bus.set_mod = 1'b0;
    step(9);
    vecs++; if ({bus.sec_tick, bus.ring} !== 2'b10) begin
      $display("FAIL ring_pre: got tick=%0b ring=%0b want tick=1 ring=0", bus.sec_tick, bus.ring); errs++; end
    step(1);
    vecs++; if ({bus.ring, bus.hours, bus.minutes, bus.seconds} !== {1'b1, 6'd7, 6'd30, 6'd0}) begin
      $display("FAIL ring_rise: got ring=%0b %0d:%0d:%0d want ring=1 7:30:0",
               bus.ring, bus.hours, bus.minutes, bus.seconds); errs++; end
    step(29);
    vecs++; if (bus.ring !== 1'b1) begin $display("FAIL ring_hold: got %0b want 1", bus.ring); errs++; end
    step(1);
    vecs++; if (bus.ring !== 1'b0) begin $display("FAIL ring_timeout: got %0b want 0", bus.ring); errs++; end
    press(0, 1, 0, 0, 1);
    vecs++; if (bus.pos !== 2'd2) begin $display("FAIL run_pos_hold: got %0d want 2", bus.pos); errs++; end
  endtask

  task automatic test_ring_cancel;
    int n;
    bus.alarm_mod = 1'b1;
    step(1);
    press(0, 1, 0, 0, 1);
    press(0, 0, 1, 0, 1);
    vecs++; if (bus.disp_minutes !== 6'd31) begin $display("FAIL cancel_alarm_31: got %0d want 31", bus.disp_minutes); errs++; end
    n = 0;
    while (bus.ring !== 1'b1 && n < 700) begin step(1); n++; end
    vecs++; if (bus.ring !== 1'b1) begin $display("FAIL cancel_wait: ring=%0b after %0d cycles want 1", bus.ring, n); errs++; end
    vecs++; if ({bus.hours, bus.minutes, bus.seconds} !== {6'd7, 6'd31, 6'd0}) begin
      $display("FAIL cancel_trig_time: got %0d:%0d:%0d want 7:31:0", bus.hours, bus.minutes, bus.seconds); errs++; end
    press(0, 0, 1, 0, 1);
    vecs++; if ({bus.ring, bus.disp_minutes} !== {1'b0, 6'd31}) begin
      $display("FAIL cancel_consume: got ring=%0b min=%0d want ring=0 min=31", bus.ring, bus.disp_minutes); errs++; end
    press(0, 0, 1, 0, 1);
    vecs++; if (bus.disp_minutes !== 6'd32) begin $display("FAIL cancel_edit_after: got %0d want 32", bus.disp_minutes); errs++; end
  endtask

  task automatic test_ring_en;
    int n;
    n = 0;
    while (bus.ring !== 1'b1 && n < 700) begin step(1); n++; end
    vecs++; if (bus.ring !== 1'b1) begin $display("FAIL en_wait: ring=%0b after %0d cycles want 1", bus.ring, n); errs++; end
    step(3);
    bus.alarm_en = 1'b0;
    step(1);
    vecs++; if (bus.ring !== 1'b0) begin $display("FAIL en_disarm: got %0b want 0", bus.ring); errs++; end
  endtask

  task automatic test_reset_mid;
    int n;
    press(0, 0, 1, 0, 1);
    bus.alarm_mod = 1'b0;
    bus.set_mod = 1'b1;
    step(1);
    press(0, 1, 0, 0, 1);
    press(0, 0, 1, 0, 1);
    bus.set_mod = 1'b0;
    bus.alarm_en = 1'b1;
    n = 0;
    while (bus.ring !== 1'b1 && n < 700) begin step(1); n++; end
    vecs++; if ({bus.ring, bus.pos} !== {1'b1, 2'd2}) begin
      $display("FAIL mid_pre: got ring=%0b pos=%0d want ring=1 pos=2", bus.ring, bus.pos); errs++; end
    reset = 1'b1;
    bus.up = 1'b1;
    step(1);
    bus.up = 1'b0;
    reset = 1'b0;
    bus.alarm_en = 1'b0;
    vecs++; if ({bus.hours, bus.minutes, bus.seconds, bus.pos, bus.ring, bus.sec_tick} !== 22'd0) begin
      $display("FAIL mid_reset_state: got %0d:%0d:%0d pos=%0d ring=%0b tick=%0b want 0:0:0 pos=0 ring=0 tick=0",
               bus.hours, bus.minutes, bus.seconds, bus.pos, bus.ring, bus.sec_tick); errs++; end
    vecs++; if ({bus.disp_hours, bus.pm, bus.disp_minutes, bus.disp_seconds} !== {6'd12, 1'b0, 6'd0, 6'd0}) begin
      $display("FAIL mid_reset_disp: got %0d pm=%0b :%0d:%0d want 12 pm=0 :0:0",
               bus.disp_hours, bus.pm, bus.disp_minutes, bus.disp_seconds); errs++; end
    bus.alarm_mod = 1'b1;
    #1;
    vecs++; if ({bus.disp_hours, bus.disp_minutes} !== {6'd12, 6'd0}) begin
      $display("FAIL mid_reset_alarm: got %0d:%0d want 12:0", bus.disp_hours, bus.disp_minutes); errs++; end
    bus.alarm_mod = 1'b0;
    #1;
  endtask

  task automatic test_12h;
    bus.set_mod = 1'b1;
    step(1);
    press(0, 0, 1, 0, 11);
    vecs++; if ({bus.disp_hours, bus.pm} !== {6'd11, 1'b0}) begin
      $display("FAIL h12_11: got %0d pm=%0b want 11 pm=0", bus.disp_hours, bus.pm); errs++; end
    press(0, 0, 1, 0, 1);
    vecs++; if ({bus.disp_hours, bus.pm} !== {6'd12, 1'b1}) begin
      $display("FAIL h12_12: got %0d pm=%0b want 12 pm=1", bus.disp_hours, bus.pm); errs++; end
    press(0, 0, 1, 0, 1);
    vecs++; if ({bus.disp_hours, bus.pm} !== {6'd1, 1'b1}) begin
      $display("FAIL h12_13: got %0d pm=%0b want 1 pm=1", bus.disp_hours, bus.pm); errs++; end
    press(0, 0, 0, 1, 14);
    vecs++; if ({bus.hours, bus.disp_hours, bus.pm} !== {6'd23, 6'd11, 1'b1}) begin
      $display("FAIL h12_23: got h=%0d disp=%0d pm=%0b want h=23 disp=11 pm=1", bus.hours, bus.disp_hours, bus.pm); errs++; end
  endtask

  task automatic test_tick_drop;
    bus.set_mod = 1'b0;
    step(9);
    vecs++; if (bus.sec_tick !== 1'b1) begin $display("FAIL drop_pre_tick: got %0b want 1", bus.sec_tick); errs++; end
    bus.set_mod = 1'b1;
    #1;
    vecs++; if (bus.sec_tick !== 1'b0) begin $display("FAIL drop_tick_masked: got %0b want 0", bus.sec_tick); errs++; end
    step(1);
    vecs++; if (bus.seconds !== 6'd0) begin $display("FAIL drop_no_inc: got %0d want 0", bus.seconds); errs++; end
    bus.set_mod = 1'b0;
    step(10);
    vecs++; if (bus.seconds !== 6'd1) begin $display("FAIL drop_resume: got %0d want 1", bus.seconds); errs++; end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b1;
    bus.set_mod = 1'b0; bus.alarm_mod = 1'b0; bus.alarm_en = 1'b0;
    bus.left = 1'b0; bus.right = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
    test_reset;
    test_run;
    test_edit;
    test_wrap;
    test_cursor;
    test_alarm_set;
    test_preset;
    test_ring;
    test_ring_cancel;
    test_ring_en;
    test_reset_mid;
    test_12h;
    test_tick_drop;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
